// File: rtl/jtdd_main_mcu_com.sv
// Main-CPU side of the Double Dragon MCU link: shared-RAM arbitration against
// mcu_ban, MCU halt/NMI control registers and a latched main-CPU interrupt.
module jtdd_main_mcu_com #(
  parameter int NMI_W = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cen6,
  input  logic [8:0] cpu_AB,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  input  logic       com_win_cs,
  input  logic       ctrl_cs,
  output logic       cpu_waitn,
  output logic       main_irqn,
  output logic       com_cs,
  input  logic       mcu_ban,
  input  logic       mcu_irqmain,
  input  logic [7:0] shared_dout,
  output logic       mcu_halt,
  output logic       mcu_nmi_set
);

  localparam logic [3:0] NMI_LD = 4'(NMI_W);

  typedef enum logic [2:0] {IDLE, WAIT, ACC, RD, HOLD} st_t;

  st_t        st_q;
  logic       waitn_q, comcs_q;
  logic [7:0] din_q;
  logic       halt_q, halt_d;
  logic [3:0] nmi_q, nmi_d;
  logic       irq_q, pend_q, pend_d;
  logic       ctrl_wr, irq_edge;

  // Shared RAM address and the upper data bits go straight to the RAM block
  logic unused_bits;
  assign unused_bits = ^{cpu_AB[8:2], cpu_dout[7:1]};

  assign ctrl_wr  = ctrl_cs & ~cpu_wrn;
  assign irq_edge = mcu_irqmain & ~irq_q;

  always_comb begin
    halt_d = halt_q;
    if (ctrl_wr && cpu_AB[1:0] == 2'd0) halt_d = cpu_dout[0];
  end

  // A reload while counting stretches the pulse instead of starting a new one
  always_comb begin
    nmi_d = nmi_q;
    if (ctrl_wr && cpu_AB[1:0] == 2'd1) nmi_d = NMI_LD;
    else if (cen6 && nmi_q != 4'd0)      nmi_d = nmi_q - 4'd1;
  end

  always_comb begin
    pend_d = pend_q;
    if (irq_edge)                             pend_d = 1'b1;
    else if (ctrl_wr && cpu_AB[1:0] == 2'd2)  pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_q <= 1'b0;
      nmi_q  <= 4'd0;
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      nmi_q  <= nmi_d;
      irq_q  <= mcu_irqmain;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= IDLE;
      waitn_q <= 1'b1;
      comcs_q <= 1'b0;
      din_q   <= 8'd0;
    end else begin
      case (st_q)
        IDLE: if (com_win_cs) begin
          waitn_q <= 1'b0;
          if (mcu_ban) st_q <= WAIT;
          else begin
            st_q    <= ACC;
            comcs_q <= 1'b1;
          end
        end
        WAIT: if (!com_win_cs) begin
          st_q    <= IDLE;
          waitn_q <= 1'b1;
        end else if (!mcu_ban && cen6) begin
          st_q    <= ACC;
          comcs_q <= 1'b1;
        end
        // MCU wins the shared mux: abandon this slot and retry once released
        ACC: if (!com_win_cs) begin
          st_q    <= IDLE;
          comcs_q <= 1'b0;
          waitn_q <= 1'b1;
        end else if (mcu_ban) begin
          st_q    <= WAIT;
          comcs_q <= 1'b0;
        end else if (cen6) begin
          st_q    <= RD;
          comcs_q <= 1'b0;
        end
        RD: if (!com_win_cs) begin
          st_q    <= IDLE;
          waitn_q <= 1'b1;
        end else if (cen6) begin
          st_q    <= HOLD;
          din_q   <= shared_dout;
          waitn_q <= 1'b1;
        end
        HOLD: if (!com_win_cs) st_q <= IDLE;
        default: begin
          st_q    <= IDLE;
          comcs_q <= 1'b0;
          waitn_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_waitn   = waitn_q;
  assign com_cs      = comcs_q;
  assign mcu_halt    = halt_q;
  assign mcu_nmi_set = nmi_q != 4'd0;
  assign main_irqn   = ~pend_q;
  assign cpu_din     = (ctrl_cs & cpu_wrn) ? {5'b0, pend_q, mcu_ban, halt_q} : din_q;

endmodule

// File: tb/tb_jtdd_main_mcu_com.sv
// Bench for jtdd_main_mcu_com: RAM model on the shared bus, table of CPU
// accesses checked through a scoreboard, plus hand sequences for NMI/IRQ/reset.
module tb_jtdd_main_mcu_com;

  logic       clk, rstn, cen6;
  logic [8:0] cpu_AB;
  logic       cpu_wrn;
  logic [7:0] cpu_dout, cpu_din;
  logic       com_win_cs, ctrl_cs, cpu_waitn, main_irqn, com_cs;
  logic       mcu_ban, mcu_irqmain;
  logic [7:0] shared_dout;
  logic       mcu_halt, mcu_nmi_set;

  logic [7:0] ram [512];
  int cen_total, wait_cen, comcs_cen, nmi_cen, nmi_rise;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    int         ban;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[9];

  jtdd_main_mcu_com #(.NMI_W(4)) dut (
    .clk(clk), .rstn(rstn), .cen6(cen6), .cpu_AB(cpu_AB), .cpu_wrn(cpu_wrn),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .com_win_cs(com_win_cs), .ctrl_cs(ctrl_cs),
    .cpu_waitn(cpu_waitn), .main_irqn(main_irqn), .com_cs(com_cs), .mcu_ban(mcu_ban),
    .mcu_irqmain(mcu_irqmain), .shared_dout(shared_dout), .mcu_halt(mcu_halt),
    .mcu_nmi_set(mcu_nmi_set)
  );

  assign shared_dout = ram[cpu_AB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cen6 every 4th clk edge
  initial begin
    int ph;
    ph = 1;
    cen6 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 4;
      cen6 = (ph == 0);
    end
  end

  // Shared RAM model and event counters, sampled between active edges
  initial begin
    logic nmi_prev;
    nmi_prev = 1'b0;
    cen_total = 0; wait_cen = 0; comcs_cen = 0; nmi_cen = 0; nmi_rise = 0;
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (cen6) cen_total++;
      if (cen6 && !cpu_waitn) wait_cen++;
      if (cen6 && com_cs) comcs_cen++;
      if (cen6 && com_cs && !cpu_wrn && !mcu_ban) ram[cpu_AB] = cpu_dout;
      if (cen6 && mcu_nmi_set) nmi_cen++;
      if (mcu_nmi_set && !nmi_prev) nmi_rise++;
      nmi_prev = mcu_nmi_set;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ctrl_wr(input logic [1:0] a, input logic [7:0] d);
    ctrl_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = {7'd0, a}; cpu_dout = d;
    step();
    ctrl_cs = 1'b0; cpu_wrn = 1'b1;
  endtask

  task automatic ctrl_rd(output logic [7:0] v);
    ctrl_cs = 1'b1; cpu_wrn = 1'b1;
    #1;
    v = cpu_din;
    ctrl_cs = 1'b0;
  endtask

  task automatic wait_cen_edge();
    int c, n;
    c = cen_total; n = 0;
    while (cen_total == c && n < 20) begin step(); n++; end
  endtask

  task automatic wait_waitn(input string name);
    int n;
    n = 0;
    while (!cpu_waitn && n < 200) begin step(); n++; end
    chk(name, cpu_waitn, 1'b1);
  endtask

  task automatic do_access(input vec_t v);
    sb_t e;
    int c0_cs, c0_w, c0_cen, n;
    logic bad;
    c0_cs = comcs_cen; c0_w = wait_cen;
    cpu_AB = v.addr; cpu_wrn = ~v.wr; cpu_dout = v.wdata;
    mcu_ban = (v.ban > 0); com_win_cs = 1'b1;
    sbq.push_back('{v.wr, v.addr, v.wr ? v.wdata : v.exp});
    step();
    chk("acc_waitn_low", cpu_waitn, 1'b0);
    if (v.ban > 0) begin
      c0_cen = cen_total; bad = 1'b0; n = 0;
      while (cen_total - c0_cen < v.ban && n < 1000) begin
        step(); n++;
        if (cpu_waitn || com_cs) bad = 1'b1;
      end
      chk("ban_hold", bad, 1'b0);
      mcu_ban = 1'b0;
    end
    wait_waitn("acc_done");
    e = sbq.pop_front();
    if (e.wr) chk("ram_write", ram[e.addr], e.data);
    else      chk("read_din", cpu_din, e.data);
    chk("comcs_pulses", comcs_cen - c0_cs, 1);
    if (v.ban == 0) chk("latency_cen", wait_cen - c0_w, 2);
    com_win_cs = 1'b0;
    step(); step();
    chk("idle_comcs", com_cs, 1'b0);
  endtask

  initial begin
    logic [7:0] st;
    int c0, r0, n;

    tbl[0] = '{1'b1, 9'h123, 8'hA5, 0,  8'h00};
    tbl[1] = '{1'b1, 9'h010, 8'h3C, 0,  8'h00};
    tbl[2] = '{1'b0, 9'h010, 8'h00, 10, 8'h3C};
    tbl[3] = '{1'b0, 9'h123, 8'h00, 0,  8'hA5};
    tbl[4] = '{1'b1, 9'h1FF, 8'h5A, 3,  8'h00};
    tbl[5] = '{1'b0, 9'h1FF, 8'h00, 0,  8'h5A};
    tbl[6] = '{1'b0, 9'h000, 8'h00, 0,  8'h00};
    tbl[7] = '{1'b1, 9'h000, 8'hC3, 0,  8'h00};
    tbl[8] = '{1'b0, 9'h000, 8'h00, 1,  8'hC3};

    // Reset with a pending access and a high IRQ line
    rstn = 1'b0; cpu_AB = 9'h010; cpu_wrn = 1'b1; cpu_dout = 8'h00;
    com_win_cs = 1'b1; ctrl_cs = 1'b0; mcu_ban = 1'b0; mcu_irqmain = 1'b1;
    repeat (3) step();
    chk("rst_waitn", cpu_waitn, 1'b1);
    chk("rst_irqn", main_irqn, 1'b1);
    chk("rst_comcs", com_cs, 1'b0);
    chk("rst_halt", mcu_halt, 1'b0);
    chk("rst_nmi", mcu_nmi_set, 1'b0);
    chk("rst_din", cpu_din, 8'h00);
    mcu_irqmain = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("fresh_access", cpu_waitn, 1'b0);
    wait_waitn("fresh_done");
    com_win_cs = 1'b0;
    step(); step();

    for (int i = 0; i < 9; i++) do_access(tbl[i]);

    // Ban raised while in ACC, before the cen6 edge
    wait_cen_edge();
    c0 = comcs_cen;
    cpu_AB = 9'h055; cpu_wrn = 1'b0; cpu_dout = 8'h77; mcu_ban = 1'b0; com_win_cs = 1'b1;
    step();
    chk("acc_comcs", com_cs, 1'b1);
    mcu_ban = 1'b1;
    step();
    chk("ban_drop_comcs", com_cs, 1'b0);
    repeat (12) step();
    chk("ban_no_write", ram[9'h055], 8'h00);
    chk("ban_no_strobe", comcs_cen - c0, 0);
    chk("ban_waitn", cpu_waitn, 1'b0);
    mcu_ban = 1'b0;
    wait_waitn("retry_done");
    chk("retry_write", ram[9'h055], 8'h77);
    com_win_cs = 1'b0; cpu_wrn = 1'b1;
    step(); step();

    // NMI pulse length and reload
    c0 = nmi_cen; r0 = nmi_rise;
    ctrl_wr(2'd1, 8'h00);
    chk("nmi_on", mcu_nmi_set, 1'b1);
    n = 0;
    while (mcu_nmi_set && n < 200) begin step(); n++; end
    chk("nmi_len", nmi_cen - c0, 4);
    chk("nmi_rises", nmi_rise - r0, 1);
    c0 = nmi_cen; r0 = nmi_rise;
    ctrl_wr(2'd1, 8'h00);
    n = 0;
    while (nmi_cen - c0 < 2 && n < 200) begin step(); n++; end
    ctrl_wr(2'd1, 8'hFF);
    n = 0;
    while (mcu_nmi_set && n < 200) begin step(); n++; end
    chk("nmi_ext_len", nmi_cen - c0, 6);
    chk("nmi_ext_rises", nmi_rise - r0, 1);

    // IRQ latch, ack, status register
    mcu_irqmain = 1'b1; step(); mcu_irqmain = 1'b0; step();
    chk("irq_set", main_irqn, 1'b0);
    ctrl_rd(st);
    chk("status_irq", st, 8'h04);
    mcu_irqmain = 1'b1;
    ctrl_wr(2'd2, 8'h00);
    chk("irq_set_wins", main_irqn, 1'b0);
    ctrl_wr(2'd2, 8'h00);
    chk("irq_ack", main_irqn, 1'b1);
    repeat (3) step();
    chk("irq_level_no_retrig", main_irqn, 1'b1);
    mcu_irqmain = 1'b0;
    ctrl_wr(2'd0, 8'h01);
    chk("halt_set", mcu_halt, 1'b1);
    ctrl_rd(st);
    chk("status_halt", st, 8'h01);
    mcu_ban = 1'b1;
    ctrl_rd(st);
    chk("status_ban", st, 8'h03);
    mcu_ban = 1'b0;
    ctrl_wr(2'd3, 8'hFF);
    ctrl_rd(st);
    chk("reg3_noop", st, 8'h01);

    // Reset asserted in the middle of a write
    ctrl_wr(2'd1, 8'h00);
    wait_cen_edge();
    cpu_AB = 9'h0AA; cpu_wrn = 1'b0; cpu_dout = 8'h99; com_win_cs = 1'b1;
    step();
    chk("mid_acc_comcs", com_cs, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_comcs", com_cs, 1'b0);
    chk("mid_rst_waitn", cpu_waitn, 1'b1);
    chk("mid_rst_halt", mcu_halt, 1'b0);
    chk("mid_rst_nmi", mcu_nmi_set, 1'b0);
    com_win_cs = 1'b0;
    repeat (8) step();
    rstn = 1'b1;
    repeat (8) step();
    chk("mid_rst_no_write", ram[9'h0AA], 8'h00);
    chk("mid_rst_comcs_after", com_cs, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtdd_main_mcu_com.md
Name: jtdd_main_mcu_com

Overview:
- Main-CPU-side counterpart of the Double Dragon MCU subsystem.
- Arbitrates main-CPU access to the 512-byte shared RAM against the MCU's bus ownership (mcu_ban), stalling the main CPU through a wait line.
- Drives the MCU halt and NMI request lines.
- Converts the MCU's main-IRQ output into a latched, acknowledgeable interrupt for the main CPU.

Parameters:
- NMI_W, 4: length of the mcu_nmi_set pulse, in cen6 pulses (1..15).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cen6  in  1  6 MHz clock enable; same enable that clocks the shared RAM
- cpu_AB  in  9  main CPU address bits [8:0]
- cpu_wrn  in  1  main CPU write strobe, active low
- cpu_dout  in  8  main CPU write data
- cpu_din  out  8  read data to main CPU (shared RAM or status)
- com_win_cs  in  1  main CPU selects the shared RAM window
- ctrl_cs  in  1  main CPU selects the control registers (cpu_AB[1:0] picks the register)
- cpu_waitn  out  1  main CPU wait, active low
- main_irqn  out  1  main CPU interrupt request, active low
- com_cs  out  1  shared RAM strobe toward the MCU block
- mcu_ban  in  1  MCU owns the shared bus
- mcu_irqmain  in  1  MCU request to interrupt the main CPU
- shared_dout  in  8  shared RAM read data
- mcu_halt  out  1  MCU halt
- mcu_nmi_set  out  1  MCU NMI request pulse

Behaviour:
- Reset values: cpu_waitn=1, main_irqn=1, com_cs=0, mcu_halt=0, mcu_nmi_set=0, cpu_din=0; state IDLE; irq_pend=0; NMI counter=0.
- Control writes: take effect on the clk edge where ctrl_cs & ~cpu_wrn. No cen6 qualification.
  - cpu_AB[1:0]=0: mcu_halt <= cpu_dout[0].
  - cpu_AB[1:0]=1: load NMI counter with NMI_W; data ignored.
  - cpu_AB[1:0]=2: clear irq_pend.
  - cpu_AB[1:0]=3: no effect.
- Control read (ctrl_cs & cpu_wrn, any address): cpu_din = {5'b0, irq_pend, mcu_ban, mcu_halt}. Combinational path, no wait.
- NMI:
  - mcu_nmi_set = (counter != 0).
  - Counter decrements on each cen6 pulse while nonzero.
  - A write to register 1 during an active pulse reloads the counter: the pulse is extended, not duplicated.
- IRQ:
  - mcu_irqmain is registered every clk. A 0->1 transition sets irq_pend; main_irqn = ~irq_pend.
  - Edge and ack (write to register 2) on the same clk: set wins.
  - A level held high does not re-trigger after an ack.
- Shared access FSM (all transitions on clk; "@cen" means the transition happens on a clk edge with cen6=1):
  - IDLE: com_win_cs=1 -> cpu_waitn<=0. Next state is WAIT if mcu_ban=1, otherwise ACC.
  - WAIT: com_cs=0. Go to ACC when mcu_ban=0 @cen.
  - ACC: com_cs=1. If mcu_ban rises, return to WAIT and drop com_cs (the MCU has priority in the shared mux, so the access is abandoned and retried). Otherwise go to RD @cen; a write completes on this edge.
  - RD: go to HOLD @cen, latching cpu_din<=shared_dout and setting cpu_waitn<=1. On writes cpu_din is still loaded but is don't-care.
  - HOLD: com_cs=0, cpu_waitn=1. Go to IDLE when com_win_cs=0. Prevents re-triggering within the same bus cycle.
  - Best-case latency, com_win_cs to cpu_waitn=1: 1 clk + 2 cen6 pulses.
- com_win_cs dropping in WAIT/ACC/RD (CPU aborted): return to IDLE, com_cs=0, cpu_waitn=1.
- mcu_halt=1 does not by itself grant the bus. Arbitration relies on mcu_ban only.
- com_cs is never asserted while mcu_ban=1 is registered for the current cycle.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously); no partial write is issued after reset release.

Test Plan:
- Reset: hold rstn=0 with com_win_cs=1 and mcu_irqmain=1 -> cpu_waitn=1, main_irqn=1, com_cs=0; after release, FSM starts a fresh access.
- Uncontended write: mcu_ban=0, write 0xA5 to address 0x123 -> com_cs high for exactly one cen6 pulse with cpu_AB=0x123; cpu_waitn low, then back to 1 after 2 cen6 pulses; a RAM model holds 0xA5 at 0x123.
- Contended read: mcu_ban=1 for 10 cen6 pulses, RAM[0x010]=0x3C -> cpu_waitn stays 0 and com_cs stays 0 throughout; then one access; cpu_din=0x3C when cpu_waitn rises.
- Ban during ACC: raise mcu_ban in ACC before the cen6 edge -> com_cs drops within 1 clk, no RAM write; access retried after mcu_ban falls.
- NMI: write register 1 -> mcu_nmi_set high for exactly 4 cen6 pulses. Write again after 2 pulses -> pulse totals 6 pulses, a single rising edge.
- IRQ/status: pulse mcu_irqmain -> main_irqn=0, status read=0x04. Ack together with a new edge -> main_irqn stays 0. Plain ack -> main_irqn=1. Write reg0=0x01 -> mcu_halt=1, status bit0=1.
